// File: rtl/core_bus_pkg.sv
// Shared types for the core bus interconnect: FSM state encoding and a select-width helper.
package core_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Slave index width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: base/mask match per slave, lowest matching index wins,
// and the local offset relative to the selected slave's base.
module bus_addr_decoder #(
    parameter int unsigned                    NUM_SLAVES = 2,
    parameter int unsigned                    AW         = 32,
    parameter int unsigned                    SEL_W      = 1,
    parameter logic [NUM_SLAVES*AW-1:0]       SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0]       SLAVE_MASK = '0
) (
    input  logic [AW-1:0]    i_addr,
    output logic             o_hit,
    output logic [SEL_W-1:0] o_sel,
    output logic [AW-1:0]    o_offset
);

    logic [AW-1:0] w_base;

    always_comb begin
        o_hit  = 1'b0;
        o_sel  = '0;
        w_base = SLAVE_BASE[AW-1:0];
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!o_hit && ((i_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW])) begin
                o_hit  = 1'b1;
                o_sel  = SEL_W'(i);
                w_base = SLAVE_BASE[i*AW +: AW];
            end
        end
    end

    // Subtraction wraps modulo 2^AW.
    assign o_offset = i_addr - w_base;

endmodule

// File: rtl/core_bus_interconnect.sv
// Single-master, N-slave interconnect: decodes a core request to one slave, holds its strobe
// until ack or timeout, and returns a one-cycle registered completion with data or error.
module core_bus_interconnect
    import core_bus_pkg::*;
#(
    parameter int unsigned                            NUM_SLAVES     = 2,
    parameter int unsigned                            ADDR_WIDTH     = 32,
    parameter int unsigned                            DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]       SLAVE_BASE     = {32'h1000_0000, 32'h0},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]       SLAVE_MASK     = {32'hF000_0000, 32'hF000_0000},
    parameter int unsigned                            TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0]                  ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 m_rd_en_i,
    input  logic                                 m_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]                m_addr_i,
    input  logic [DATA_WIDTH-1:0]                m_data_i,
    output logic [DATA_WIDTH-1:0]                m_data_o,
    output logic                                 m_ack_o,
    output logic                                 m_err_o,
    output logic [NUM_SLAVES-1:0]                s_rd_en_o,
    output logic [NUM_SLAVES-1:0]                s_wr_en_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic [DATA_WIDTH-1:0]                s_data_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_data_i,
    input  logic [NUM_SLAVES-1:0]                s_ack_i
);

    localparam int unsigned SEL_W = sel_width(NUM_SLAVES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  r_state,   w_state_nxt;
    logic [SEL_W-1:0]        r_sel,     w_sel_nxt;
    logic                    r_is_rd,   w_is_rd_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr,    w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata_nxt;
    logic [NUM_SLAVES-1:0]   r_s_rd,    w_s_rd_nxt;
    logic [NUM_SLAVES-1:0]   r_s_wr,    w_s_wr_nxt;
    logic [DATA_WIDTH-1:0]   r_m_data,  w_m_data_nxt;
    logic                    r_m_ack,   w_m_ack_nxt;
    logic                    r_m_err,   w_m_err_nxt;
    logic [CNT_W-1:0]        r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_inc;

    logic                    w_dec_hit;
    logic [SEL_W-1:0]        w_dec_sel;
    logic [ADDR_WIDTH-1:0]   w_dec_offset;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_sel_ack;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (ADDR_WIDTH),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .i_addr   (m_addr_i),
        .o_hit    (w_dec_hit),
        .o_sel    (w_dec_sel),
        .o_offset (w_dec_offset)
    );

    assign w_onehot  = NUM_SLAVES'(1) << w_dec_sel;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Only the latched slave's ack and read data are seen.
    always_comb begin
        w_sel_ack   = 1'b0;
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ack   = s_ack_i[i];
                w_sel_rdata = s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_is_rd  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_s_rd   <= '0;
            r_s_wr   <= '0;
            r_m_data <= '0;
            r_m_ack  <= 1'b0;
            r_m_err  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_is_rd  <= w_is_rd_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_s_rd   <= w_s_rd_nxt;
            r_s_wr   <= w_s_wr_nxt;
            r_m_data <= w_m_data_nxt;
            r_m_ack  <= w_m_ack_nxt;
            r_m_err  <= w_m_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // ERR is a one-cycle settle; the error completion itself is issued in RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_is_rd_nxt  = r_is_rd;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_s_rd_nxt   = '0;
        w_s_wr_nxt   = '0;
        w_m_data_nxt = '0;
        w_m_ack_nxt  = 1'b0;
        w_m_err_nxt  = 1'b0;
        w_cnt_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (m_rd_en_i || m_wr_en_i) begin
                    w_sel_nxt   = w_dec_sel;
                    w_is_rd_nxt = m_rd_en_i;
                    w_addr_nxt  = w_dec_offset;
                    w_wdata_nxt = m_data_i;
                    if (w_dec_hit && (m_rd_en_i ^ m_wr_en_i)) begin
                        w_state_nxt = WAIT;
                        w_s_rd_nxt  = m_rd_en_i ? w_onehot : '0;
                        w_s_wr_nxt  = m_wr_en_i ? w_onehot : '0;
                    end else begin
                        w_state_nxt = ERR;
                    end
                end
            end
            WAIT: begin
                if (w_sel_ack) begin
                    w_state_nxt  = RESP;
                    w_m_ack_nxt  = 1'b1;
                    w_m_data_nxt = r_is_rd ? w_sel_rdata : '0;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    w_state_nxt = ERR;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_s_rd_nxt = r_s_rd;
                    w_s_wr_nxt = r_s_wr;
                end
            end
            ERR: begin
                w_state_nxt  = RESP;
                w_m_ack_nxt  = 1'b1;
                w_m_err_nxt  = 1'b1;
                w_m_data_nxt = ERR_DATA;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m_data_o  = r_m_data;
    assign m_ack_o   = r_m_ack;
    assign m_err_o   = r_m_err;
    assign s_rd_en_o = r_s_rd;
    assign s_wr_en_o = r_s_wr;
    assign s_addr_o  = r_addr;
    assign s_data_o  = r_wdata;

endmodule

// File: tb/tb_core_bus_interconnect.sv
// Directed bench for core_bus_interconnect: reads, writes, unmapped, timeout, overlap of
// rd/wr, spurious acks and reset mid-transaction, all with hand-computed expectations.
module tb_core_bus_interconnect;

    logic        clk;
    logic        rst_n;
    logic        m_rd_en_i;
    logic        m_wr_en_i;
    logic [31:0] m_addr_i;
    logic [31:0] m_data_i;
    logic [31:0] m_data_o;
    logic        m_ack_o;
    logic        m_err_o;
    logic [1:0]  s_rd_en_o;
    logic [1:0]  s_wr_en_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [63:0] s_data_i;
    logic [1:0]  s_ack_i;

    int n_asserts = 0;
    int n_fail    = 0;
    int strobe_cycles;
    int lat;

    core_bus_interconnect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_rd_en_i (m_rd_en_i),
        .m_wr_en_i (m_wr_en_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_rd_en_o (s_rd_en_o),
        .s_wr_en_o (s_wr_en_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        m_rd_en_i = 1'b0;
        m_wr_en_i = 1'b0;
        s_ack_i   = 2'b00;
        s_data_i  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        m_addr_i  = '0;
        m_data_i  = '0;
        idle_bus();
        tick();
        tick();
        chk("rst_ack",   32'(m_ack_o),   32'h0);
        chk("rst_err",   32'(m_err_o),   32'h0);
        chk("rst_mdata", m_data_o,       32'h0);
        chk("rst_srd",   32'(s_rd_en_o), 32'h0);
        chk("rst_swr",   32'(s_wr_en_o), 32'h0);
        chk("rst_saddr", s_addr_o,       32'h0);
        chk("rst_sdata", s_data_o,       32'h0);
        rst_n = 1'b1;
        tick();

        // Read slave0 @0x10, ack two cycles after the strobe.
        m_rd_en_i = 1'b1; m_addr_i = 32'h0000_0010;
        tick();
        chk("rd0_strobe", 32'(s_rd_en_o), 32'h1);
        chk("rd0_nowr",   32'(s_wr_en_o), 32'h0);
        chk("rd0_saddr",  s_addr_o,       32'h10);
        chk("rd0_noack1", 32'(m_ack_o),   32'h0);
        tick();
        chk("rd0_hold",   32'(s_rd_en_o), 32'h1);
        chk("rd0_noack2", 32'(m_ack_o),   32'h0);
        tick();
        s_ack_i = 2'b01; s_data_i[31:0] = 32'h1234_5678;
        chk("rd0_hold3",  32'(s_rd_en_o), 32'h1);
        tick();
        chk("rd0_ack",    32'(m_ack_o),   32'h1);
        chk("rd0_err",    32'(m_err_o),   32'h0);
        chk("rd0_data",   m_data_o,       32'h1234_5678);
        chk("rd0_strdn",  32'(s_rd_en_o), 32'h0);
        idle_bus();
        tick();
        chk("rd0_pulse",  32'(m_ack_o),   32'h0);
        chk("rd0_dclr",   m_data_o,       32'h0);

        // Write slave1 @0x1000_0004, zero-wait ack.
        m_wr_en_i = 1'b1; m_addr_i = 32'h1000_0004; m_data_i = 32'hCAFE_F00D;
        tick();
        chk("wr1_strobe", 32'(s_wr_en_o), 32'h2);
        chk("wr1_nord",   32'(s_rd_en_o), 32'h0);
        chk("wr1_saddr",  s_addr_o,       32'h4);
        chk("wr1_sdata",  s_data_o,       32'hCAFE_F00D);
        s_ack_i = 2'b10;
        tick();
        chk("wr1_ack",    32'(m_ack_o),   32'h1);
        chk("wr1_err",    32'(m_err_o),   32'h0);
        chk("wr1_data",   m_data_o,       32'h0);
        chk("wr1_strdn",  32'(s_wr_en_o), 32'h0);
        idle_bus();
        tick();
        chk("wr1_pulse",  32'(m_ack_o),   32'h0);

        // Unmapped read: no strobe, error completion at cycle 2.
        m_rd_en_i = 1'b1; m_addr_i = 32'h2000_0000;
        tick();
        chk("um_nord",    32'(s_rd_en_o), 32'h0);
        chk("um_nowr",    32'(s_wr_en_o), 32'h0);
        chk("um_noack",   32'(m_ack_o),   32'h0);
        tick();
        chk("um_ack",     32'(m_ack_o),   32'h1);
        chk("um_err",     32'(m_err_o),   32'h1);
        chk("um_data",    m_data_o,       32'hDEAD_BEEF);
        idle_bus();
        tick();
        chk("um_errclr",  32'(m_err_o),   32'h0);

        // Slave1 never acks: strobe held 16 cycles, then error.
        m_rd_en_i = 1'b1; m_addr_i = 32'h1000_0008;
        strobe_cycles = 0;
        lat = 0;
        while (!m_ack_o && lat < 40) begin
            tick();
            lat++;
            if (s_rd_en_o == 2'b10) strobe_cycles++;
        end
        chk("to_strobes", 32'(strobe_cycles), 32'd16);
        chk("to_latency", 32'(lat),           32'd18);
        chk("to_err",     32'(m_err_o),       32'h1);
        chk("to_data",    m_data_o,           32'hDEAD_BEEF);
        idle_bus();
        tick();

        // Ack on the expiry cycle wins over the timeout.
        m_rd_en_i = 1'b1; m_addr_i = 32'h1000_0008;
        for (int c = 1; c <= 16; c++) tick();
        chk("toa_strobe", 32'(s_rd_en_o), 32'h2);
        chk("toa_noack",  32'(m_ack_o),   32'h0);
        s_ack_i = 2'b10; s_data_i[63:32] = 32'hA5A5_0001;
        tick();
        chk("toa_ack",    32'(m_ack_o),   32'h1);
        chk("toa_err",    32'(m_err_o),   32'h0);
        chk("toa_data",   m_data_o,       32'hA5A5_0001);
        idle_bus();
        tick();

        // rd and wr together: error, no strobe.
        m_rd_en_i = 1'b1; m_wr_en_i = 1'b1; m_addr_i = 32'h0000_0000;
        tick();
        chk("rw_nord",    32'(s_rd_en_o), 32'h0);
        chk("rw_nowr",    32'(s_wr_en_o), 32'h0);
        tick();
        chk("rw_ack",     32'(m_ack_o),   32'h1);
        chk("rw_err",     32'(m_err_o),   32'h1);
        chk("rw_data",    m_data_o,       32'hDEAD_BEEF);
        idle_bus();
        tick();

        // Spurious ack from slave0 while slave1 is selected.
        m_rd_en_i = 1'b1; m_addr_i = 32'h1000_0000;
        tick();
        chk("sp_strobe",  32'(s_rd_en_o), 32'h2);
        s_ack_i = 2'b01; s_data_i = {32'h5555_AAAA, 32'hFFFF_0000};
        tick();
        chk("sp_noack1",  32'(m_ack_o),   32'h0);
        chk("sp_hold",    32'(s_rd_en_o), 32'h2);
        s_ack_i = 2'b10;
        tick();
        chk("sp_ack",     32'(m_ack_o),   32'h1);
        chk("sp_err",     32'(m_err_o),   32'h0);
        chk("sp_data",    m_data_o,       32'h5555_AAAA);
        idle_bus();
        tick();

        // Reset in WAIT drops the strobe at once and issues no response.
        m_wr_en_i = 1'b1; m_addr_i = 32'h0000_0020; m_data_i = 32'h0000_0077;
        tick();
        chk("ra_strobe",  32'(s_wr_en_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_async",   32'(s_wr_en_o), 32'h0);
        tick();
        chk("ra_noack",   32'(m_ack_o),   32'h0);
        idle_bus();
        rst_n = 1'b1;
        tick();
        chk("ra_noack2",  32'(m_ack_o),   32'h0);
        m_rd_en_i = 1'b1; m_addr_i = 32'h1000_000C;
        tick();
        chk("ra2_strobe", 32'(s_rd_en_o), 32'h2);
        chk("ra2_saddr",  s_addr_o,       32'hC);
        s_ack_i = 2'b10; s_data_i[63:32] = 32'h0BAD_CAFE;
        tick();
        chk("ra2_ack",    32'(m_ack_o),   32'h1);
        chk("ra2_err",    32'(m_err_o),   32'h0);
        chk("ra2_data",   m_data_o,       32'h0BAD_CAFE);
        idle_bus();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
